shift_add_scaler_pipe: RTL

- Pipelined, multi-lane, constant-coefficient fixed-point scaler.
- Each lane computes out = ±(Σ ±(a >>> SHIFTk)) over up to four shift terms. Used for CORDIC gain compensation and other fixed constant multiplies in the QR/rotation datapath.
- Generalises the combinational shift-add scaler in four ways:
  - parametrised terms and signs;
  - optional rounding and saturation;
  - selectable negation mode;
  - valid/ready pipeline with backpressure, plus a sticky overflow flag.

---
 rtl/shift_add_scaler_pipe_pkg.sv | 21 ++
 rtl/shift_add_lane.sv | 41 ++++
 rtl/shift_add_scaler_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/shift_add_scaler_pipe_pkg.sv
// Shared constants and the saturation helper for the shift-add scaler pipeline.
package shift_add_scaler_pipe_pkg;

  localparam int NTERMS   = 4;
  localparam int GUARD    = 2;
  localparam int NEG_ONES = 0;
  localparam int NEG_TWOS = 1;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/shift_add_lane.sv
// One lane of combinational term formation: four shifted copies of the sample,
// optionally rounded and subtracted, folded into two partial sums.
module shift_add_lane
  import shift_add_scaler_pipe_pkg::*;
#(
  parameter int         DATA_WIDTH = 20,
  parameter int         SHIFT0     = 1,
  parameter int         SHIFT1     = 3,
  parameter int         SHIFT2     = 4,
  parameter int         SHIFT3     = 0,
  parameter logic [3:0] TERM_EN    = 4'b0111,
  parameter logic [3:0] TERM_SUB   = 4'b0000,
  parameter int         ROUND      = 0
) (
  input  logic signed [DATA_WIDTH-1:0]       a_i,
  output logic signed [DATA_WIDTH+GUARD-1:0] p01_o,
  output logic signed [DATA_WIDTH+GUARD-1:0] p23_o
);

  localparam int EW = DATA_WIDTH + GUARD;
  localparam int SH_ARR [NTERMS] = '{SHIFT0, SHIFT1, SHIFT2, SHIFT3};

  logic signed [EW-1:0] a_ext;
  logic signed [EW-1:0] term [NTERMS];

  assign a_ext = {{GUARD{a_i[DATA_WIDTH-1]}}, a_i};

  for (genvar k = 0; k < NTERMS; k++) begin : g_term
    localparam int S = SH_ARR[k];
    // Half an LSB of the shifted result; a zero shift has nothing to round.
    localparam logic signed [EW-1:0] RND =
      (ROUND != 0 && S > 0) ? (EW'(1) << (S > 0 ? S - 1 : 0)) : '0;
    logic signed [EW-1:0] shifted;
    assign shifted = (a_ext + RND) >>> S;
    assign term[k] = TERM_EN[k] ? (TERM_SUB[k] ? -shifted : shifted) : '0;
  end

  assign p01_o = term[0] + term[1];
  assign p23_o = term[2] + term[3];

endmodule

// File: rtl/shift_add_scaler_pipe.sv
// Two-stage, multi-lane constant-coefficient shift-add scaler with valid/ready
// backpressure, selectable negation, saturation and a sticky overflow flag.
module shift_add_scaler_pipe
  import shift_add_scaler_pipe_pkg::*;
#(
  parameter int         DATA_WIDTH = 20,
  parameter int         FRAC       = 16,
  parameter int         LANES      = 2,
  parameter int         SHIFT0     = 1,
  parameter int         SHIFT1     = 3,
  parameter int         SHIFT2     = 4,
  parameter int         SHIFT3     = 0,
  parameter logic [3:0] TERM_EN    = 4'b0111,
  parameter logic [3:0] TERM_SUB   = 4'b0000,
  parameter int         ROUND      = 0,
  parameter int         NEG_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LANES-1:0]            in_neg,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        sat_flag
);

  localparam int EW = DATA_WIDTH + GUARD;
  localparam int W  = LANES * DATA_WIDTH;

  // FRAC only documents where the binary point sits; the arithmetic ignores it.
  if (FRAC > DATA_WIDTH) begin : g_frac_beyond_width
  end

  // Handshake: a beat moves on any edge where valid && ready are both high;
  // valid and data are held by the sender until then. A stage advances when it
  // is empty or when the stage after it advances, so in_ready never looks at
  // in_valid.
  logic stage1_adv, stage2_adv, accept, load2;
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic sat_q, sat_d;
  logic signed [EW-1:0] p01 [LANES];
  logic signed [EW-1:0] p23 [LANES];
  logic signed [EW-1:0] s1_p01_q [LANES];
  logic signed [EW-1:0] s1_p23_q [LANES];
  logic [LANES-1:0] s1_neg_q;
  logic [LANES-1:0] lane_clip;
  logic [W-1:0]     res;
  logic [W-1:0]     out_data_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] negated;
    logic signed [EW-1:0] signed_res;
    logic signed [63:0]   wide;

    shift_add_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .SHIFT0    (SHIFT0),
      .SHIFT1    (SHIFT1),
      .SHIFT2    (SHIFT2),
      .SHIFT3    (SHIFT3),
      .TERM_EN   (TERM_EN),
      .TERM_SUB  (TERM_SUB),
      .ROUND     (ROUND)
    ) u_lane (
      .a_i  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .p01_o(p01[i]),
      .p23_o(p23[i])
    );

    assign sum        = s1_p01_q[i] + s1_p23_q[i];
    assign negated    = (NEG_MODE == NEG_TWOS) ? -sum : ~sum;
    assign signed_res = s1_neg_q[i] ? negated : sum;
    assign wide       = signed_res;
    assign res[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sat_clip(wide, DATA_WIDTH));
    assign lane_clip[i] = (sat_clip(wide, DATA_WIDTH) != wide);
  end

  assign stage2_adv = !out_valid_q || out_ready;
  assign stage1_adv = !s1_valid_q || stage2_adv;
  assign accept     = in_valid && stage1_adv && !clr;
  assign load2      = stage2_adv && s1_valid_q && !clr;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (clr) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      sat_d       = 1'b0;
    end else begin
      if (stage1_adv) s1_valid_d = in_valid;
      if (stage2_adv) out_valid_d = s1_valid_q;
      if (load2) sat_d = sat_q | (|lane_clip);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        s1_p01_q[i] <= '0;
        s1_p23_q[i] <= '0;
      end
      s1_neg_q   <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          s1_p01_q[i] <= p01[i];
          s1_p23_q[i] <= p23[i];
        end
        s1_neg_q <= in_neg;
      end
      if (load2) out_data_q <= res;
    end
  end

  assign in_ready  = stage1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule
